// File: rtl/core_pkg.sv
// core_pkg: opcode constants, write-back select encoding, hazard FSM states
// and the ID/EX pipeline register layout shared by the decode/execute front end.
//
// Contents:
//   OPCODE_*                 RV32I major opcodes (instr[6:0])
//   write_back_mux_selector  register-file write-back source select
//   hazard_state_e           load-use hazard FSM states (RUN, LU_STALL)
//   id_ex_t / ID_EX_BUBBLE   ID/EX register contents and the bubble value
package core_pkg;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        NO_WRITEBACK  = 2'd0,
        ALU_WRITEBACK = 2'd1,
        MEM_WRITEBACK = 2'd2,
        PC_WRITEBACK  = 2'd3
    } write_back_mux_selector;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hazard_state_e;

    typedef struct packed {
        logic                   valid;
        logic [6:0]             opcode;
        logic [4:0]             rs1;
        logic [4:0]             rs2;
        logic [4:0]             rd;
        write_back_mux_selector wb_mux;
    } id_ex_t;

    // Inert instruction: no register writes, never matches a load-use check.
    localparam id_ex_t ID_EX_BUBBLE = '{
        valid:  1'b0,
        opcode: 7'd0,
        rs1:    5'd0,
        rs2:    5'd0,
        rd:     5'd0,
        wb_mux: NO_WRITEBACK
    };

endpackage

// File: rtl/reg_use_decode.sv
// reg_use_decode: reports which source register fields an opcode actually reads.
//
// Ports:
//   opcode    in   7  major opcode of the instruction
//   uses_rs1  out  1  instruction reads rs1
//   uses_rs2  out  1  instruction reads rs2
module reg_use_decode
    import core_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       uses_rs1,
    output logic       uses_rs2
);

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPCODE_OP, OPCODE_BRANCH, OPCODE_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPCODE_LOAD, OPCODE_JALR, OPCODE_OPIMM: begin
                uses_rs1 = 1'b1;
            end
            default: begin
                // LUI, AUIPC, JAL, SYSTEM, unknown: register fields are not sources.
            end
        endcase
    end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage: ID/EX pipeline register with load-use hazard detection.
// A load in ID/EX whose destination is read by the ID instruction stalls
// IF/ID for exactly one cycle and injects a bubble; forwarding handles the rest.
//
// Build option: define HAZ_STALL_CNT_EN to implement the saturating stall
// counter; otherwise stall_cnt_op is tied to zero and no counter exists.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   id_valid_ip           IF/ID holds a real instruction
//   id_opcode_ip          ID opcode
//   id_rs1/rs2/rd_ip      ID register fields
//   id_wb_mux_ip          ID write-back select
//   hold_ip               global freeze: all state holds, no stall asserted
//   flush_ip              squash the ID instruction (remembered across hold)
//   id_instr_opcode_op,
//   ID_dest_rs1/rs2/rd_op registered ID/EX fields
//   id_ex_wb_mux_op       registered write-back select
//   id_ex_valid_op        ID/EX holds a real instruction
//   stall_op              combinational: hold PC and IF/ID this cycle
//   stall_cnt_op          number of load-use stall cycles (saturating)
module id_ex_hazard_stage
    import core_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid_ip,
    input  logic [6:0]             id_opcode_ip,
    input  logic [4:0]             id_rs1_ip,
    input  logic [4:0]             id_rs2_ip,
    input  logic [4:0]             id_rd_ip,
    input  write_back_mux_selector id_wb_mux_ip,
    input  logic                   hold_ip,
    input  logic                   flush_ip,
    output logic [6:0]             id_instr_opcode_op,
    output logic [4:0]             ID_dest_rs1_op,
    output logic [4:0]             ID_dest_rs2_op,
    output logic [4:0]             ID_dest_rd_op,
    output write_back_mux_selector id_ex_wb_mux_op,
    output logic                   id_ex_valid_op,
    output logic                   stall_op,
    output logic [CNT_W-1:0]       stall_cnt_op
);

    hazard_state_e state_q, state_d;
    logic          flush_pend_q, flush_pend_d;
    id_ex_t        ex_q, ex_d;

    logic uses_rs1, uses_rs2;
    logic load_in_ex, rs1_hit, rs2_hit, hazard, eff_flush, stall;

    reg_use_decode u_reg_use_decode (
        .opcode   (id_opcode_ip),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    // x0 never carries a real dependency, so a load to x0 is ignored.
    assign load_in_ex = ex_q.valid && (ex_q.opcode == OPCODE_LOAD) && (ex_q.rd != 5'd0);
    assign rs1_hit    = uses_rs1 && (id_rs1_ip == ex_q.rd);
    assign rs2_hit    = uses_rs2 && (id_rs2_ip == ex_q.rd);
    assign hazard     = load_in_ex && id_valid_ip && (rs1_hit || rs2_hit);

    // A flush seen during hold is applied on the first cycle the pipe moves.
    assign eff_flush  = flush_ip || flush_pend_q;

    // Only one stall cycle per load: LU_STALL never re-stalls.
    assign stall      = hazard && (state_q == RUN) && !hold_ip && !eff_flush;
    assign stall_op   = stall;

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        ex_d         = ex_q;
        if (hold_ip) begin
            flush_pend_d = flush_pend_q || flush_ip;
        end else begin
            flush_pend_d = 1'b0;
            // Flush forces RUN; otherwise LU_STALL lasts exactly one moving cycle.
            state_d      = stall ? LU_STALL : RUN;
            if (stall || eff_flush || !id_valid_ip) begin
                ex_d = ID_EX_BUBBLE;
            end else begin
                ex_d.valid  = 1'b1;
                ex_d.opcode = id_opcode_ip;
                ex_d.rs1    = id_rs1_ip;
                ex_d.rs2    = id_rs2_ip;
                ex_d.rd     = id_rd_ip;
                ex_d.wb_mux = id_wb_mux_ip;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            flush_pend_q <= 1'b0;
            ex_q         <= ID_EX_BUBBLE;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            ex_q         <= ex_d;
        end
    end

    assign id_instr_opcode_op = ex_q.opcode;
    assign ID_dest_rs1_op     = ex_q.rs1;
    assign ID_dest_rs2_op     = ex_q.rs2;
    assign ID_dest_rd_op      = ex_q.rd;
    assign id_ex_wb_mux_op    = ex_q.wb_mux;
    assign id_ex_valid_op     = ex_q.valid;

`ifdef HAZ_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // stall is already qualified by !hold_ip.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_op = stall_cnt_q;
`else
    assign stall_cnt_op = '0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Self-checking bench for id_ex_hazard_stage: directed scenarios plus a random
// run compared against a cycle-level behavioural model of the stage.
module tb_id_ex_hazard_stage;
    import core_pkg::*;

    localparam int CNT_W = 2;
`ifdef HAZ_STALL_CNT_EN
    localparam int CNT_MAX = 3;
`else
    localparam int CNT_MAX = 0;
`endif

    logic                   clk;
    logic                   reset;
    logic                   id_valid_ip;
    logic [6:0]             id_opcode_ip;
    logic [4:0]             id_rs1_ip, id_rs2_ip, id_rd_ip;
    write_back_mux_selector id_wb_mux_ip;
    logic                   hold_ip, flush_ip;
    logic [6:0]             id_instr_opcode_op;
    logic [4:0]             ID_dest_rs1_op, ID_dest_rs2_op, ID_dest_rd_op;
    write_back_mux_selector id_ex_wb_mux_op;
    logic                   id_ex_valid_op;
    logic                   stall_op;
    logic [CNT_W-1:0]       stall_cnt_op;

    int errors = 0;
    int checks = 0;

    // Behavioural model of what ID/EX should hold and what the stage remembers.
    bit                     m_valid;
    logic [6:0]             m_op;
    logic [4:0]             m_rs1, m_rs2, m_rd;
    write_back_mux_selector m_wb;
    bit                     m_just_stalled;
    bit                     m_pend;
    int                     m_cnt;

    id_ex_hazard_stage #(.CNT_W(CNT_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .id_valid_ip        (id_valid_ip),
        .id_opcode_ip       (id_opcode_ip),
        .id_rs1_ip          (id_rs1_ip),
        .id_rs2_ip          (id_rs2_ip),
        .id_rd_ip           (id_rd_ip),
        .id_wb_mux_ip       (id_wb_mux_ip),
        .hold_ip            (hold_ip),
        .flush_ip           (flush_ip),
        .id_instr_opcode_op (id_instr_opcode_op),
        .ID_dest_rs1_op     (ID_dest_rs1_op),
        .ID_dest_rs2_op     (ID_dest_rs2_op),
        .ID_dest_rd_op      (ID_dest_rd_op),
        .id_ex_wb_mux_op    (id_ex_wb_mux_op),
        .id_ex_valid_op     (id_ex_valid_op),
        .stall_op           (stall_op),
        .stall_cnt_op       (stall_cnt_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {OPCODE_OP, OPCODE_BRANCH, OPCODE_STORE,
                          OPCODE_LOAD, OPCODE_JALR, OPCODE_OPIMM};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {OPCODE_OP, OPCODE_BRANCH, OPCODE_STORE};
    endfunction

    function automatic bit model_stall();
        bit dep;
        if (hold_ip || flush_ip || m_pend || m_just_stalled) return 1'b0;
        if (!(m_valid && m_op == OPCODE_LOAD && m_rd != 5'd0 && id_valid_ip)) return 1'b0;
        dep = (reads_rs1(id_opcode_ip) && id_rs1_ip == m_rd) ||
              (reads_rs2(id_opcode_ip) && id_rs2_ip == m_rd);
        return dep;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_op = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_wb = NO_WRITEBACK;
        m_just_stalled = 0; m_pend = 0; m_cnt = 0;
    endtask

    task automatic set_id(input bit v, input logic [6:0] op, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] rd,
                          input write_back_mux_selector wb);
        id_valid_ip = v; id_opcode_ip = op; id_rs1_ip = r1; id_rs2_ip = r2;
        id_rd_ip = rd; id_wb_mux_ip = wb;
    endtask

    task automatic set_ctl(input bit h, input bit f);
        hold_ip = h; flush_ip = f;
    endtask

    // Advance one clock; the model takes the inputs the DUT samples at the edge.
    task automatic step();
        bit st, squash;
        st = model_stall();
        squash = flush_ip || m_pend;
        @(posedge clk);
        #1;
        if (hold_ip) begin
            m_pend = m_pend || flush_ip;
        end else begin
            m_pend = 0;
            if (st || squash || !id_valid_ip) begin
                m_valid = 0; m_op = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
                m_wb = NO_WRITEBACK;
            end else begin
                m_valid = 1; m_op = id_opcode_ip; m_rs1 = id_rs1_ip; m_rs2 = id_rs2_ip;
                m_rd = id_rd_ip; m_wb = id_wb_mux_ip;
            end
            m_just_stalled = st;
            if (st && m_cnt < CNT_MAX) m_cnt++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_ctl(0, 0);
        set_id(0, '0, '0, '0, '0, NO_WRITEBACK);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_ctl(0, 0);
        set_id(1, OPCODE_OP, 5'd3, 5'd4, 5'd9, ALU_WRITEBACK);
        repeat (2) @(posedge clk);
        #2;
        checks++; if (id_ex_valid_op !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %0b expected 0", id_ex_valid_op); end
        checks++; if (id_instr_opcode_op !== 7'd0) begin errors++;
            $display("FAIL reset_opcode: got %0h expected 0", id_instr_opcode_op); end
        checks++; if ({ID_dest_rs1_op, ID_dest_rs2_op, ID_dest_rd_op} !== 15'd0) begin errors++;
            $display("FAIL reset_regs: got %0h/%0h/%0h expected 0/0/0",
                     ID_dest_rs1_op, ID_dest_rs2_op, ID_dest_rd_op); end
        checks++; if (id_ex_wb_mux_op !== NO_WRITEBACK) begin errors++;
            $display("FAIL reset_wb: got %0d expected %0d", id_ex_wb_mux_op, NO_WRITEBACK); end
        checks++; if (stall_cnt_op !== '0) begin errors++;
            $display("FAIL reset_cnt: got %0d expected 0", stall_cnt_op); end
        checks++; if (stall_op !== 1'b0) begin errors++;
            $display("FAIL reset_stall: got %0b expected 0", stall_op); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // lw x5 ; add x6,x5,x7
    task automatic test_load_use();
        do_reset();
        set_id(1, OPCODE_LOAD, 5'd1, 5'd0, 5'd5, MEM_WRITEBACK);
        step();
        set_id(1, OPCODE_OP, 5'd5, 5'd7, 5'd6, ALU_WRITEBACK);
        #1;
        checks++; if (stall_op !== 1'b1) begin errors++;
            $display("FAIL lu_stall: got %0b expected 1", stall_op); end
        step();
        checks++; if (id_ex_valid_op !== 1'b0 || id_ex_wb_mux_op !== NO_WRITEBACK) begin errors++;
            $display("FAIL lu_bubble: valid=%0b wb=%0d expected valid=0 wb=0",
                     id_ex_valid_op, id_ex_wb_mux_op); end
        checks++; if (stall_cnt_op !== CNT_W'(CNT_MAX > 0 ? 1 : 0)) begin errors++;
            $display("FAIL lu_cnt: got %0d expected %0d", stall_cnt_op, CNT_MAX > 0 ? 1 : 0); end
        checks++; if (stall_op !== 1'b0) begin errors++;
            $display("FAIL lu_one_cycle: got %0b expected 0", stall_op); end
        step();
        checks++; if (id_ex_valid_op !== 1'b1 || id_instr_opcode_op !== OPCODE_OP ||
                      ID_dest_rs1_op !== 5'd5 || ID_dest_rs2_op !== 5'd7 ||
                      ID_dest_rd_op !== 5'd6 || id_ex_wb_mux_op !== ALU_WRITEBACK) begin errors++;
            $display("FAIL lu_add_issued: got v=%0b op=%0h rs1=%0d rs2=%0d rd=%0d wb=%0d expected 1/33/5/7/6/1",
                     id_ex_valid_op, id_instr_opcode_op, ID_dest_rs1_op, ID_dest_rs2_op,
                     ID_dest_rd_op, id_ex_wb_mux_op); end
    endtask

    task automatic test_no_hazard();
        do_reset();
        set_id(1, OPCODE_LOAD, 5'd1, 5'd0, 5'd0, MEM_WRITEBACK);
        step();
        set_id(1, OPCODE_OP, 5'd0, 5'd0, 5'd6, ALU_WRITEBACK);
        #1;
        checks++; if (stall_op !== 1'b0) begin errors++;
            $display("FAIL nh_x0: got %0b expected 0", stall_op); end
        step();
        set_id(1, OPCODE_LOAD, 5'd1, 5'd0, 5'd5, MEM_WRITEBACK);
        step();
        set_id(1, OPCODE_OPIMM, 5'd7, 5'd5, 5'd6, ALU_WRITEBACK);
        #1;
        checks++; if (stall_op !== 1'b0) begin errors++;
            $display("FAIL nh_addi_rs2: got %0b expected 0", stall_op); end
        step();
        checks++; if (id_ex_valid_op !== 1'b1 || id_instr_opcode_op !== OPCODE_OPIMM) begin errors++;
            $display("FAIL nh_addi_issued: got v=%0b op=%0h expected 1/13",
                     id_ex_valid_op, id_instr_opcode_op); end
        set_id(1, OPCODE_LOAD, 5'd1, 5'd0, 5'd5, MEM_WRITEBACK);
        step();
        set_id(0, OPCODE_OP, 5'd5, 5'd5, 5'd6, ALU_WRITEBACK);
        #1;
        checks++; if (stall_op !== 1'b0) begin errors++;
            $display("FAIL nh_invalid_id: got %0b expected 0", stall_op); end
        set_id(1, OPCODE_STORE, 5'd9, 5'd5, 5'd0, NO_WRITEBACK);
        #1;
        checks++; if (stall_op !== 1'b1) begin errors++;
            $display("FAIL store_rs2_stall: got %0b expected 1", stall_op); end
        step();
    endtask

    task automatic test_flush_priority();
        do_reset();
        set_id(1, OPCODE_LOAD, 5'd1, 5'd0, 5'd5, MEM_WRITEBACK);
        step();
        set_id(1, OPCODE_OP, 5'd5, 5'd7, 5'd6, ALU_WRITEBACK);
        set_ctl(0, 1);
        #1;
        checks++; if (stall_op !== 1'b0) begin errors++;
            $display("FAIL flush_no_stall: got %0b expected 0", stall_op); end
        step();
        checks++; if (id_ex_valid_op !== 1'b0 || id_ex_wb_mux_op !== NO_WRITEBACK) begin errors++;
            $display("FAIL flush_bubble: valid=%0b wb=%0d expected 0/0",
                     id_ex_valid_op, id_ex_wb_mux_op); end
        checks++; if (stall_cnt_op !== '0) begin errors++;
            $display("FAIL flush_cnt: got %0d expected 0", stall_cnt_op); end
        set_ctl(0, 0);
        step();
        checks++; if (id_ex_valid_op !== 1'b1 || ID_dest_rd_op !== 5'd6) begin errors++;
            $display("FAIL flush_then_run: v=%0b rd=%0d expected 1/6", id_ex_valid_op, ID_dest_rd_op); end
    endtask

    task automatic test_flush_hold();
        do_reset();
        set_id(1, OPCODE_OP, 5'd1, 5'd2, 5'd6, ALU_WRITEBACK);
        step();
        set_id(1, OPCODE_OP, 5'd3, 5'd4, 5'd9, ALU_WRITEBACK);
        for (int i = 0; i < 3; i++) begin
            set_ctl(1, i == 0);
            #1;
            checks++; if (stall_op !== 1'b0) begin errors++;
                $display("FAIL hold_stall: cycle %0d got %0b expected 0", i, stall_op); end
            step();
            checks++; if (id_ex_valid_op !== 1'b1 || ID_dest_rd_op !== 5'd6) begin errors++;
                $display("FAIL hold_frozen: cycle %0d v=%0b rd=%0d expected 1/6",
                         i, id_ex_valid_op, ID_dest_rd_op); end
        end
        set_ctl(0, 0);
        step();
        checks++; if (id_ex_valid_op !== 1'b0 || ID_dest_rd_op !== 5'd0) begin errors++;
            $display("FAIL pend_flush_bubble: v=%0b rd=%0d expected 0/0", id_ex_valid_op, ID_dest_rd_op); end
        step();
        checks++; if (id_ex_valid_op !== 1'b1 || ID_dest_rd_op !== 5'd9) begin errors++;
            $display("FAIL pend_cleared: v=%0b rd=%0d expected 1/9", id_ex_valid_op, ID_dest_rd_op); end
        // Hold masks a live hazard.
        set_id(1, OPCODE_LOAD, 5'd1, 5'd0, 5'd5, MEM_WRITEBACK);
        step();
        set_id(1, OPCODE_BRANCH, 5'd5, 5'd0, 5'd0, NO_WRITEBACK);
        set_ctl(1, 0);
        #1;
        checks++; if (stall_op !== 1'b0) begin errors++;
            $display("FAIL hold_masks_hazard: got %0b expected 0", stall_op); end
        step();
        set_ctl(0, 0);
        #1;
        checks++; if (stall_op !== 1'b1) begin errors++;
            $display("FAIL hazard_after_hold: got %0b expected 1", stall_op); end
        step();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(1, OPCODE_LOAD, 5'd1, 5'd0, 5'd5, MEM_WRITEBACK);
        step();
        set_id(1, OPCODE_OP, 5'd5, 5'd7, 5'd6, ALU_WRITEBACK);
        step();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (id_ex_valid_op !== 1'b0 || id_instr_opcode_op !== 7'd0 ||
                      id_ex_wb_mux_op !== NO_WRITEBACK) begin errors++;
            $display("FAIL rst_mid_bubble: v=%0b op=%0h wb=%0d expected 0/0/0",
                     id_ex_valid_op, id_instr_opcode_op, id_ex_wb_mux_op); end
        checks++; if (stall_cnt_op !== '0) begin errors++;
            $display("FAIL rst_mid_cnt: got %0d expected 0", stall_cnt_op); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        set_id(1, OPCODE_LOAD, 5'd1, 5'd0, 5'd5, MEM_WRITEBACK);
        step();
        set_id(1, OPCODE_OP, 5'd5, 5'd7, 5'd6, ALU_WRITEBACK);
        #1;
        checks++; if (stall_op !== 1'b1) begin errors++;
            $display("FAIL rst_mid_run: got %0b expected 1", stall_op); end
        step();
    endtask

    task automatic test_stall_counter();
        do_reset();
        for (int n = 1; n <= 5; n++) begin
            set_id(1, OPCODE_LOAD, 5'd1, 5'd0, 5'd5, MEM_WRITEBACK);
            step();
            set_id(1, OPCODE_OP, 5'd5, 5'd7, 5'd6, ALU_WRITEBACK);
            step();
            step();
            checks++; if (stall_cnt_op !== CNT_W'(n < CNT_MAX ? n : CNT_MAX)) begin errors++;
                $display("FAIL cnt_after_%0d: got %0d expected %0d",
                         n, stall_cnt_op, n < CNT_MAX ? n : CNT_MAX); end
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [6];
        ops[0] = OPCODE_LOAD; ops[1] = OPCODE_OP; ops[2] = OPCODE_OPIMM;
        ops[3] = OPCODE_STORE; ops[4] = OPCODE_BRANCH; ops[5] = OPCODE_LUI;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_id($urandom_range(0, 9) != 0, ops[$urandom_range(0, 5)],
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), write_back_mux_selector'($urandom_range(0, 3)));
            set_ctl($urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
            #1;
            checks++; if (stall_op !== model_stall()) begin errors++;
                $display("FAIL rnd_stall: cycle %0d got %0b expected %0b", i, stall_op, model_stall()); end
            step();
            checks++; if (id_ex_valid_op !== m_valid || id_instr_opcode_op !== m_op ||
                          ID_dest_rs1_op !== m_rs1 || ID_dest_rs2_op !== m_rs2 ||
                          ID_dest_rd_op !== m_rd || id_ex_wb_mux_op !== m_wb ||
                          stall_cnt_op !== CNT_W'(m_cnt)) begin errors++;
                $display("FAIL rnd_idex: cycle %0d got v=%0b op=%0h r=%0d/%0d/%0d wb=%0d c=%0d expected v=%0b op=%0h r=%0d/%0d/%0d wb=%0d c=%0d",
                         i, id_ex_valid_op, id_instr_opcode_op, ID_dest_rs1_op, ID_dest_rs2_op,
                         ID_dest_rd_op, id_ex_wb_mux_op, stall_cnt_op,
                         m_valid, m_op, m_rs1, m_rs2, m_rd, m_wb, m_cnt); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_flush_priority();
        test_flush_hold();
        test_reset_mid_stall();
        test_stall_counter();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_stage.md
ID_EX_HAZARD_STAGE -- requirements
Module: id_ex_hazard_stage

Interface
REQ-001 Parameter CNT_W, default 16: width of stall-cycle counter.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 id_valid_ip  input  1  IF/ID holds a real instruction.
REQ-005 id_opcode_ip  input  7  decoded opcode (CORE_PKG opcode constants).
REQ-006 id_rs1_ip / id_rs2_ip / id_rd_ip  input  5 each  decoded register fields.
REQ-007 id_wb_mux_ip  input  write_back_mux_selector  decoded write-back select.
REQ-008 hold_ip  input  1  global freeze (memory wait); holds all state.
REQ-009 flush_ip  input  1  taken branch/jump resolved in EX; squash ID instruction.
REQ-010 id_instr_opcode_op, ID_dest_rs1_op, ID_dest_rs2_op, ID_dest_rd_op  output  7/5/5/5  registered ID/EX fields feeding forward control.
REQ-011 id_ex_wb_mux_op  output  write_back_mux_selector  registered write-back select.
REQ-012 id_ex_valid_op  output  1  ID/EX holds a real instruction.
REQ-013 stall_op  output  1  combinational; holds PC and IF/ID this cycle.
REQ-014 stall_cnt_op  output  CNT_W  load-use stall cycles counted.

Function
REQ-015 Register use: OP, BRANCH, STORE read rs1 and rs2; LOAD, JALR, OPIMM read rs1 only; all other opcodes read none.
REQ-016 Load-use hazard = id_ex_valid_op && id_instr_opcode_op==OPCODE_LOAD && ID_dest_rd_op!=0 && ID_dest_rd_op matches a register read by id_opcode_ip && id_valid_ip.
REQ-017 States: RUN, LU_STALL. RUN->LU_STALL on hazard (not hold, not flush); LU_STALL->RUN unconditionally next non-hold cycle.
REQ-018 stall_op = hazard && state==RUN && !hold_ip && !effective flush; stall_op=0 in LU_STALL (one-cycle stall maximum, forwarding covers MEM/WB).
REQ-019 Bubble: on stall or effective flush, next ID/EX = valid 0, opcode 0, rs1/rs2/rd 0, wb_mux NO_WRITEBACK.
REQ-020 Otherwise, non-hold cycle: ID/EX loads ID fields; valid = id_valid_ip; invalid ID loads a bubble.
REQ-021 hold_ip=1: ID/EX, state, counter unchanged; stall_op=0.
REQ-022 flush_ip during hold sets flush_pend; effective flush = flush_ip || flush_pend on first non-hold cycle, then flush_pend clears.
REQ-023 Flush has priority over stall; flush in LU_STALL returns state to RUN.
REQ-024 stall_cnt_op increments by 1 per cycle stall_op=1, saturates at all-ones.
REQ-025 Latency: ID fields appear on outputs one cycle after capture.

Reset
REQ-026 reset asynchronously forces: state RUN, all ID/EX outputs bubble values, valid 0, flush_pend 0, stall_cnt_op 0.
REQ-027 Reset asserted mid-stall aborts the stall; first post-reset cycle is RUN.

Configuration
REQ-028 Macro HAZ_STALL_CNT_EN defined: counter per REQ-024 implemented.
REQ-029 Macro undefined: no counter flops; stall_cnt_op tied to 0.

Structure
REQ-030 CORE_PKG holds opcode constants, write_back_mux_selector, and a new hazard_state_e enum (RUN, LU_STALL).
REQ-031 Sub-module reg_use_decode (combinational: opcode -> uses_rs1, uses_rs2) instantiated for the ID instruction.

Verification
REQ-032 lw x5 in ID/EX, add x6,x5,x7 in ID -> stall_op=1 one cycle, ID/EX bubble (wb NO_WRITEBACK), add in ID/EX next cycle, stall_cnt_op=1.
REQ-033 lw x0 then add x6,x0,x0; lw x5 then addi x6,x7,1 with rs2 field=5 -> stall_op=0 both cases.
REQ-034 Hazard plus flush_ip=1 same cycle -> stall_op=0, bubble next cycle, state RUN, counter unchanged.
REQ-035 flush_ip=1 during hold_ip=1 for 3 cycles -> outputs frozen; first cycle after hold loads bubble.
REQ-036 reset pulse while in LU_STALL -> outputs bubble immediately, counter 0, state RUN.
REQ-037 With HAZ_STALL_CNT_EN, CNT_W=2, 5 stalls -> stall_cnt_op=3; without macro -> 0.
